btb_assoc: RTL

- Parametrised set-associative branch target buffer for the fetch-stage branch predictor.
- Keeps a tag, a word-aligned target and a 2-bit saturating direction counter per way, with tree pseudo-LRU replacement per set.
- Lookup result is registered with 1-cycle latency. Execute-stage resolution updates or allocates entries.
- A sweep FSM initialises the arrays after reset and on flush, so the storage arrays need no reset.

---
 rtl/bpu_pkg.sv | 20 ++
 rtl/btb_plru.sv | 80 ++++++++
 rtl/btb_assoc.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/bpu_pkg.sv
// rtl/bpu_pkg.sv - shared branch-predictor types: direction counter, sweep FSM states, counter update.
package bpu_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'd0;
  localparam ctr_t WNT = 2'd1;
  localparam ctr_t WT  = 2'd2;
  localparam ctr_t ST  = 2'd3;

  typedef enum logic {INIT = 1'b0, IDLE = 1'b1} btb_state_t;

  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    if (taken) begin
      return (c == ST) ? ST : c + 2'd1;
    end
    return (c == SNT) ? SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/btb_plru.sv
// rtl/btb_plru.sv - per-set tree pseudo-LRU state with two touch ports and a victim read port.
// A node bit of 1 points the victim search at the upper half of that subtree.
module btb_plru #(
  parameter int SETS = 64,
  parameter int WAYS = 2
) (
  input  logic                                      i_clk,
  input  logic                                      i_clr,
  input  logic [$clog2(SETS)-1:0]                   i_clr_idx,
  input  logic                                      i_lk_touch,
  input  logic [$clog2(SETS)-1:0]                   i_lk_idx,
  input  logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0] i_lk_way,
  input  logic                                      i_up_touch,
  input  logic [$clog2(SETS)-1:0]                   i_up_idx,
  input  logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0] i_up_way,
  input  logic [$clog2(SETS)-1:0]                   i_vic_idx,
  output logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0] o_victim
);

  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int NB    = (WAYS > 1) ? WAYS - 1 : 1;

  function automatic logic [NB-1:0] f_touch(input logic [NB-1:0] bits, input logic [WAY_W-1:0] way);
    logic [NB-1:0] b;
    int            node;
    logic          dir;
    b    = bits;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      dir     = way[WAY_W-1-l];
      b[node] = ~dir;
      node    = 2 * node + 1 + int'(dir);
    end
    return b;
  endfunction

  function automatic logic [WAY_W-1:0] f_victim(input logic [NB-1:0] bits);
    logic [WAY_W-1:0] v;
    int               node;
    logic             dir;
    v    = '0;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      dir            = bits[node];
      v[WAY_W-1-l]   = dir;
      node           = 2 * node + 1 + int'(dir);
    end
    return v;
  endfunction

  generate
    if (WAYS > 1) begin : g_tree
      logic [NB-1:0] r_tree [SETS];
      logic [NB-1:0] w_vic_bits;

      // Same-set collision: the update port wins over the lookup touch.
      always_ff @(posedge i_clk) begin
        if (i_clr) begin
          r_tree[i_clr_idx] <= '0;
        end else begin
          if (i_lk_touch && !(i_up_touch && (i_up_idx == i_lk_idx))) begin
            r_tree[i_lk_idx] <= f_touch(r_tree[i_lk_idx], i_lk_way);
          end
          if (i_up_touch) begin
            r_tree[i_up_idx] <= f_touch(r_tree[i_up_idx], i_up_way);
          end
        end
      end

      assign w_vic_bits = r_tree[i_vic_idx];
      assign o_victim   = f_victim(w_vic_bits);
    end else begin : g_none
      logic w_unused;
      assign w_unused = ^{i_clk, i_clr, i_clr_idx, i_lk_touch, i_lk_idx, i_lk_way,
                          i_up_touch, i_up_idx, i_up_way, i_vic_idx};
      assign o_victim = '0;
    end
  endgenerate

endmodule

// File: rtl/btb_assoc.sv
// rtl/btb_assoc.sv - set-associative BTB with 2-bit counters, tree-PLRU replacement and init/flush sweep.
// Optional macro BTB_PERF_EN adds lookup/hit performance counters.
module btb_assoc
  import bpu_pkg::*;
#(
  parameter int   ADDR_WIDTH = 32,
  parameter int   SETS       = 64,
  parameter int   WAYS       = 2,
  parameter ctr_t CNT_INIT   = 2'b10
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  output logic                  o_ready,
  input  logic                  i_lookup_valid,
  input  logic [ADDR_WIDTH-1:0] i_lookup_addr,
  output logic                  o_pred_valid,
  output logic                  o_pred_hit,
  output logic                  o_pred_taken,
  output logic [ADDR_WIDTH-1:0] o_pred_addr,
`ifdef BTB_PERF_EN
  output logic [31:0]           o_perf_lookups,
  output logic [31:0]           o_perf_hits,
`endif
  input  logic                  i_upd_valid,
  input  logic [ADDR_WIDTH-1:0] i_upd_pc,
  input  logic [ADDR_WIDTH-1:0] i_upd_target,
  input  logic                  i_upd_taken
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;
  localparam int TGT_W = ADDR_WIDTH - 2;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  btb_state_t       r_state, w_state_nxt;
  logic [IDX_W-1:0] r_sweep, w_sweep_nxt;
  logic             w_clr, w_ready;

  // Storage is deliberately unreset; the sweep clears valid bits before use.
  logic [WAYS-1:0]  r_valid [SETS];
  logic [TAG_W-1:0] r_tag   [SETS][WAYS];
  logic [TGT_W-1:0] r_tgt   [SETS][WAYS];
  ctr_t             r_ctr   [SETS][WAYS];

  logic [IDX_W-1:0] w_lk_idx, w_up_idx;
  logic [TAG_W-1:0] w_lk_tag, w_up_tag;
  logic             w_lk_hit, w_lk_dir, w_lk_touch;
  logic [WAY_W-1:0] w_lk_way;
  logic [TGT_W-1:0] w_lk_tgt;
  logic             w_up_hit, w_has_inv, w_upd_en, w_up_touch;
  logic [WAY_W-1:0] w_up_way, w_inv_way, w_victim, w_alloc_way, w_up_wr_way;
  logic             w_unused;

  logic                  r_pred_valid, r_pred_hit, r_pred_taken;
  logic [ADDR_WIDTH-1:0] r_pred_addr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= INIT;
      r_sweep <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sweep <= w_sweep_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sweep_nxt = r_sweep;
    case (r_state)
      INIT: begin
        if (i_flush) begin
          w_sweep_nxt = '0;
        end else if (r_sweep == IDX_W'(SETS - 1)) begin
          w_state_nxt = IDLE;
          w_sweep_nxt = '0;
        end else begin
          w_sweep_nxt = r_sweep + 1'b1;
        end
      end
      IDLE: begin
        if (i_flush) begin
          w_state_nxt = INIT;
          w_sweep_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = INIT;
        w_sweep_nxt = '0;
      end
    endcase
  end

  always_comb begin
    w_clr   = (r_state == INIT);
    w_ready = (r_state == IDLE);
  end

  assign o_ready  = w_ready;
  assign w_lk_idx = i_lookup_addr[IDX_W+1:2];
  assign w_lk_tag = i_lookup_addr[ADDR_WIDTH-1:IDX_W+2];
  assign w_up_idx = i_upd_pc[IDX_W+1:2];
  assign w_up_tag = i_upd_pc[ADDR_WIDTH-1:IDX_W+2];
  assign w_unused = ^{i_lookup_addr[1:0], i_upd_pc[1:0], i_upd_target[1:0]};

  always_comb begin
    w_lk_hit = 1'b0;
    w_lk_way = '0;
    w_lk_tgt = '0;
    w_lk_dir = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_lk_idx][w] && (r_tag[w_lk_idx][w] == w_lk_tag)) begin
        w_lk_hit = w_ready;
        w_lk_way = WAY_W'(w);
        w_lk_tgt = r_tgt[w_lk_idx][w];
        w_lk_dir = r_ctr[w_lk_idx][w][1];
      end
    end
  end

  always_comb begin
    w_up_hit  = 1'b0;
    w_up_way  = '0;
    w_has_inv = 1'b0;
    w_inv_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_up_idx][w] && (r_tag[w_up_idx][w] == w_up_tag)) begin
        w_up_hit = 1'b1;
        w_up_way = WAY_W'(w);
      end
    end
    // Descending scan so the lowest invalid way is the one that sticks.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w_up_idx][w]) begin
        w_has_inv = 1'b1;
        w_inv_way = WAY_W'(w);
      end
    end
  end

  assign w_alloc_way = w_has_inv ? w_inv_way : w_victim;
  assign w_up_wr_way = w_up_hit ? w_up_way : w_alloc_way;
  assign w_upd_en    = w_ready & i_upd_valid & ~i_flush;
  assign w_up_touch  = w_upd_en & (w_up_hit | i_upd_taken);
  assign w_lk_touch  = i_lookup_valid & w_lk_hit;

  always_ff @(posedge i_clk) begin
    if (w_clr) begin
      r_valid[r_sweep] <= '0;
    end else if (w_up_touch) begin
      if (w_up_hit) begin
        r_ctr[w_up_idx][w_up_wr_way] <= ctr_next(r_ctr[w_up_idx][w_up_wr_way], i_upd_taken);
        if (i_upd_taken) begin
          r_tgt[w_up_idx][w_up_wr_way] <= i_upd_target[ADDR_WIDTH-1:2];
        end
      end else begin
        r_valid[w_up_idx][w_up_wr_way] <= 1'b1;
        r_tag[w_up_idx][w_up_wr_way]   <= w_up_tag;
        r_tgt[w_up_idx][w_up_wr_way]   <= i_upd_target[ADDR_WIDTH-1:2];
        r_ctr[w_up_idx][w_up_wr_way]   <= CNT_INIT;
      end
    end
  end

  btb_plru #(
    .SETS (SETS),
    .WAYS (WAYS)
  ) u_plru (
    .i_clk      (i_clk),
    .i_clr      (w_clr),
    .i_clr_idx  (r_sweep),
    .i_lk_touch (w_lk_touch),
    .i_lk_idx   (w_lk_idx),
    .i_lk_way   (w_lk_way),
    .i_up_touch (w_up_touch),
    .i_up_idx   (w_up_idx),
    .i_up_way   (w_up_wr_way),
    .i_vic_idx  (w_up_idx),
    .o_victim   (w_victim)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pred_valid <= 1'b0;
      r_pred_hit   <= 1'b0;
      r_pred_taken <= 1'b0;
      r_pred_addr  <= '0;
    end else begin
      r_pred_valid <= i_lookup_valid;
      r_pred_hit   <= w_lk_touch;
      r_pred_taken <= w_lk_touch & w_lk_dir;
      r_pred_addr  <= w_lk_touch ? {w_lk_tgt, 2'b00} : '0;
    end
  end

  assign o_pred_valid = r_pred_valid;
  assign o_pred_hit   = r_pred_hit;
  assign o_pred_taken = r_pred_taken;
  assign o_pred_addr  = r_pred_addr;

`ifdef BTB_PERF_EN
  logic [31:0] r_perf_lookups, r_perf_hits;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_perf_lookups <= '0;
      r_perf_hits    <= '0;
    end else if (i_flush) begin
      r_perf_lookups <= '0;
      r_perf_hits    <= '0;
    end else if (i_lookup_valid && w_ready) begin
      r_perf_lookups <= r_perf_lookups + 32'd1;
      if (w_lk_hit) begin
        r_perf_hits <= r_perf_hits + 32'd1;
      end
    end
  end

  assign o_perf_lookups = r_perf_lookups;
  assign o_perf_hits    = r_perf_hits;
`endif

endmodule
